// File: rtl/uart_reg_responder.sv
// uart_reg_responder: turns UART FIFO byte traffic into register bus accesses.
// Optional inter-byte abort: define UART_RESP_TIMEOUT_EN (response 0x54).
module uart_reg_responder #(
    parameter int DBIT           = 8,
    parameter int AW             = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DBIT-1:0] r_data,
    input  logic            rx_empty,
    output logic            rd_uart,
    output logic [DBIT-1:0] w_data,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [AW-1:0]   reg_addr,
    output logic [DBIT-1:0] reg_wdata,
    output logic            reg_we,
    output logic            reg_re,
    input  logic [DBIT-1:0] reg_rdata,
    output logic            busy
);

    localparam logic [DBIT-1:0] OP_WR   = DBIT'(8'h57);
    localparam logic [DBIT-1:0] OP_RD   = DBIT'(8'h52);
    localparam logic [DBIT-1:0] RSP_ACK = DBIT'(8'h4B);
    localparam logic [DBIT-1:0] RSP_ERR = DBIT'(8'h3F);
    localparam logic [DBIT-1:0] RSP_TMO = DBIT'(8'h54);

    if (AW > DBIT || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_reg_responder: need AW <= DBIT and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_WRITE,
        S_READ,
        S_READ_CAP,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [DBIT-1:0] r_op;

    state_t          w_state_n;
    logic [1:0]      w_idx_n;
    logic [DBIT-1:0] w_op_n;
    logic [AW-1:0]   w_addr_n;
    logic [DBIT-1:0] w_wdata_n;
    logic [DBIT-1:0] w_resp_n;
    logic            w_rd_n;
    logic            w_wr_n;
    logic            w_we_n;
    logic            w_re_n;
    logic            w_tmo;

`ifdef UART_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    assign w_tmo = (r_state == S_POP) && (r_idx != 2'd0) && rx_empty &&
                   (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Inter-byte timer: restarts on every capture, runs only while starved mid-command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_cnt <= '0;
        end else if (r_state == S_POP && r_idx != 2'd0 && rx_empty) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_op_n    = r_op;
        w_addr_n  = reg_addr;
        w_wdata_n = reg_wdata;
        w_resp_n  = w_data;
        w_rd_n    = 1'b0;
        w_wr_n    = 1'b0;
        w_we_n    = 1'b0;
        w_re_n    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!rx_empty) begin
                    w_state_n = S_CAPTURE;
                    w_rd_n    = 1'b1;
                end
            end
            S_POP: begin
                if (!rx_empty) begin
                    w_state_n = S_CAPTURE;
                    w_rd_n    = 1'b1;
                end else if (w_tmo) begin
                    w_state_n = S_RESP;
                    w_resp_n  = RSP_TMO;
                end
            end
            // First cycle has the pop strobe high; the byte arrives the cycle after.
            S_CAPTURE: begin
                if (!rd_uart) begin
                    w_idx_n = r_idx + 2'd1;
                    unique case (r_idx)
                        2'd0: begin
                            w_op_n = r_data;
                            if (r_data == OP_WR || r_data == OP_RD) begin
                                w_state_n = S_POP;
                            end else begin
                                w_state_n = S_RESP;
                                w_resp_n  = RSP_ERR;
                            end
                        end
                        2'd1: begin
                            w_addr_n = r_data[AW-1:0];
                            if (r_op == OP_RD) begin
                                w_state_n = S_READ;
                                w_re_n    = 1'b1;
                            end else begin
                                w_state_n = S_POP;
                            end
                        end
                        default: begin
                            w_wdata_n = r_data;
                            w_state_n = S_WRITE;
                            w_we_n    = 1'b1;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                w_state_n = S_RESP;
                w_resp_n  = RSP_ACK;
            end
            S_READ: begin
                w_state_n = S_READ_CAP;
            end
            S_READ_CAP: begin
                w_state_n = S_RESP;
                w_resp_n  = reg_rdata;
            end
            S_RESP: begin
                if (!tx_full) begin
                    w_state_n = S_IDLE;
                    w_idx_n   = 2'd0;
                    w_wr_n    = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_idx_n   = 2'd0;
            end
        endcase
    end

    // State, command slots and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_op      <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            w_data    <= '0;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_op      <= w_op_n;
            reg_addr  <= w_addr_n;
            reg_wdata <= w_wdata_n;
            w_data    <= w_resp_n;
            rd_uart   <= w_rd_n;
            wr_uart   <= w_wr_n;
            reg_we    <= w_we_n;
            reg_re    <= w_re_n;
            busy      <= (w_state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: FIFO/register-bus models, vector table, corner
// sequences and a randomized command stream checked against a command-level model.
module tb_uart_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rd_uart;
    logic [7:0] w_data;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    uart_reg_responder #(.DBIT(8), .AW(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .r_data(r_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .w_data(w_data), .tx_full(tx_full),
        .wr_uart(wr_uart), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rx_buf [4096];
    int         rx_wp = 0;
    int         rx_rp = 0;
    logic [7:0] txq [$];
    logic [7:0] regs [256];
    logic       loaded = 1'b0;
    int rd_cnt = 0, we_cnt = 0, re_cnt = 0, cyc = 0, re_cyc = 0, wr_cyc = 0;
    logic [7:0] we_addr = 0, we_data = 0, re_addr = 0;
    logic       rx_pend = 0, bus_pend = 0, prev_rd = 0, prev_full = 0;
    logic [7:0] rx_pv = 0, bus_pv = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[rx_wp] = b;
        rx_wp++;
    endtask

    task automatic wait_tx(input int want, input int budget);
        int k = 0;
        while (txq.size() < want && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    // FIFO and register-bus models; read data is only valid the cycle after its strobe.
    always @(negedge clk) begin
        cyc++;
        if (!loaded) begin
            for (int i = 0; i < 256; i++) regs[i] = 8'(i * 5 + 1);
            regs[8'h12] = 8'h3C;
            regs[8'h00] = 8'h81;
            regs[8'h07] = 8'h77;
            loaded = 1'b1;
        end
        if (rst) begin
            rx_pend = 0;
            bus_pend = 0;
            prev_rd = 0;
        end else begin
            r_data = rx_pend ? rx_pv : 8'($urandom);
            reg_rdata = bus_pend ? bus_pv : 8'($urandom);
            rx_pend = 0;
            bus_pend = 0;
            if (rd_uart) begin
                n_vec++;
                if (prev_rd || rx_rp == rx_wp) begin
                    n_bad++;
                    $display("FAIL rd_strobe: back2back=%0d empty=%0d",
                             prev_rd, rx_rp == rx_wp);
                end
                if (rx_rp != rx_wp) begin
                    rx_pv = rx_buf[rx_rp];
                    rx_rp++;
                    rx_pend = 1;
                end
                rd_cnt++;
            end
            if (reg_re) begin
                bus_pv = regs[reg_addr];
                bus_pend = 1;
                re_cnt++;
                re_addr = reg_addr;
                re_cyc = cyc;
            end
            if (reg_we) begin
                regs[reg_addr] = reg_wdata;
                we_cnt++;
                we_addr = reg_addr;
                we_data = reg_wdata;
            end
            if (wr_uart) begin
                n_vec++;
                if (prev_full) begin
                    n_bad++;
                    $display("FAIL wr_while_full: got push %0h, want none", w_data);
                end
                txq.push_back(w_data);
                wr_cyc = cyc;
            end
            prev_rd = rd_uart;
        end
        prev_full = tx_full;
        rx_empty = (rx_rp == rx_wp);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        logic [7:0] rsp;
        int         we, re;
        logic [7:0] addr, wd;
    } vec_t;

    initial begin
        vec_t       tbl[8];
        logic [7:0] model_mem [256];
        logic [7:0] expq [$];
        logic [7:0] a, d, op;
        int base, we0, re0, rd0, k, mism;

        tbl[0] = '{8'h57, 8'h05, 8'hA5, 3, 8'h4B, 1, 0, 8'h05, 8'hA5};
        tbl[1] = '{8'h52, 8'h05, 8'h00, 2, 8'hA5, 0, 1, 8'h05, 8'h00};
        tbl[2] = '{8'h52, 8'h12, 8'h00, 2, 8'h3C, 0, 1, 8'h12, 8'h00};
        tbl[3] = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 0, 0, 8'h00, 8'h00};
        tbl[4] = '{8'h52, 8'h00, 8'h00, 2, 8'h81, 0, 1, 8'h00, 8'h00};
        tbl[5] = '{8'h57, 8'hFF, 8'h00, 3, 8'h4B, 1, 0, 8'hFF, 8'h00};
        tbl[6] = '{8'h52, 8'hFF, 8'h00, 2, 8'h00, 0, 1, 8'hFF, 8'h00};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1, 8'h3F, 0, 0, 8'h00, 8'h00};

        tick(3);
        chk("rst_strobes", {rd_uart, wr_uart, reg_we, reg_re, busy}, 0);
        chk("rst_data", {w_data, reg_addr, reg_wdata}, 0);
        rst = 1'b0;
        tick(3);
        chk("idle_busy", {busy, rd_uart}, 0);

        for (int i = 0; i < 8; i++) begin
            base = txq.size();
            we0 = we_cnt;
            re0 = re_cnt;
            push(tbl[i].b0);
            if (tbl[i].nb > 1) push(tbl[i].b1);
            if (tbl[i].nb > 2) push(tbl[i].b2);
            wait_tx(base + 1, 300);
            tick(5);
            chk($sformatf("tbl%0d_count", i), txq.size() - base, 1);
            chk($sformatf("tbl%0d_rsp", i), txq[base], tbl[i].rsp);
            chk($sformatf("tbl%0d_we", i), we_cnt - we0, tbl[i].we);
            chk($sformatf("tbl%0d_re", i), re_cnt - re0, tbl[i].re);
            if (tbl[i].we != 0) begin
                chk($sformatf("tbl%0d_waddr", i), we_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_wdata", i), we_data, tbl[i].wd);
            end
            if (tbl[i].re != 0) begin
                chk($sformatf("tbl%0d_raddr", i), re_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_rd_lat", i), (wr_cyc - re_cyc) >= 2, 1);
            end
        end

        // Backpressure: response held, no further pops, then exactly one push.
        base = txq.size();
        tx_full = 1'b1;
        push(8'h52);
        push(8'h12);
        tick(12);
        rd0 = rd_cnt;
        push(8'h57);
        push(8'h20);
        push(8'h5A);
        tick(50);
        chk("bp_no_pop", rd_cnt - rd0, 0);
        chk("bp_no_push", txq.size() - base, 0);
        chk("bp_busy", busy, 1);
        chk("bp_wdata", w_data, 8'h3C);
        tx_full = 1'b0;
        wait_tx(base + 2, 300);
        tick(5);
        chk("bp_count", txq.size() - base, 2);
        chk("bp_rsp", txq[base], 8'h3C);
        chk("bp_next_rsp", txq[base + 1], 8'h4B);
        chk("bp_next_reg", regs[8'h20], 8'h5A);

        // Reset after two bytes of a write: nothing emitted, nothing written.
        base = txq.size();
        rd0 = rd_cnt;
        we0 = we_cnt;
        push(8'h57);
        push(8'h07);
        k = 0;
        while (rd_cnt < rd0 + 2 && k < 100) begin
            tick(1);
            k++;
        end
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {rd_uart, wr_uart, reg_we, reg_re, busy}, 0);
        chk("mid_rst_data", {w_data, reg_addr, reg_wdata}, 0);
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("mid_rst_no_rsp", txq.size() - base, 0);
        chk("mid_rst_no_we", we_cnt - we0, 0);
        push(8'h52);
        push(8'h07);
        wait_tx(base + 1, 300);
        tick(3);
        chk("mid_rst_read", txq[base], 8'h77);

`ifdef UART_RESP_TIMEOUT_EN
        // Starved write: aborted with 0x54 and no bus access.
        base = txq.size();
        we0 = we_cnt;
        push(8'h57);
        push(8'h01);
        wait_tx(base + 1, 400);
        tick(3);
        chk("tmo_count", txq.size() - base, 1);
        chk("tmo_rsp", txq[base], 8'h54);
        chk("tmo_no_we", we_cnt - we0, 0);
`endif

        // Randomized stream against a command-level model.
        for (int i = 0; i < 256; i++) model_mem[i] = regs[i];
        base = txq.size();
        for (int c = 0; c < 40; c++) begin
            k = $urandom_range(0, 2);
            a = 8'($urandom);
            d = 8'($urandom);
            if (k == 0) begin
                model_mem[a] = d;
                expq.push_back(8'h4B);
                push(8'h57);
                push(a);
                push(d);
            end else if (k == 1) begin
                expq.push_back(model_mem[a]);
                push(8'h52);
                push(a);
            end else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                expq.push_back(8'h3F);
                push(op);
            end
            repeat ($urandom_range(0, 4)) begin
                tx_full = ($urandom_range(0, 3) == 0);
                tick(1);
            end
        end
        tx_full = 1'b0;
        wait_tx(base + expq.size(), 5000);
        tick(5);
        chk("rand_count", txq.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            chk($sformatf("rand_rsp%0d", i), txq[base + i], expq[i]);
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (regs[i] !== model_mem[i]) mism++;
        chk("rand_regfile", mism, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
